// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination-tag pipeline that detects RAW hazards
// between the instruction in ID and up to DEPTH older uncommitted instructions.
// It freezes PC/IF/ID on a hazard or memory wait and counts frozen cycles.
// Optional build macro: HAZARD_FWD_EN (forwarding selects, load-use stall only).
module hazard_scoreboard #(
    parameter int RADDR_W = 4,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16,
    localparam int FSEL_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [RADDR_W-1:0]   src1,
    input  logic [RADDR_W-1:0]   src2,
    input  logic                 two_src,
    input  logic                 issue_wb_en,
    input  logic                 issue_mem_r,
    input  logic [RADDR_W-1:0]   issue_dest,
    input  logic                 flush,
    input  logic                 mem_stall,
    output logic                 freeze,
    output logic [FSEL_W-1:0]    fwd_sel1,
    output logic [FSEL_W-1:0]    fwd_sel2,
    output logic [CNT_W-1:0]     stall_cycles
);

    // Tag entry k: index 0 is the instruction in EXE, DEPTH-1 the oldest.
    logic [DEPTH-1:0]   tag_vld;
    logic [DEPTH-1:0]   tag_wb;
    logic [DEPTH-1:0]   tag_memr;
    logic [RADDR_W-1:0] tag_dest [DEPTH];

    logic [DEPTH-1:0]   match1;
    logic [DEPTH-1:0]   match2;
    logic               hit1;
    logic               hit2;
    logic               hazard;
    logic               accept;
    logic               unused_memr;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) return c;
        return c + CNT_W'(1);
    endfunction

    // Per-entry destination compares against both ID source indices.
    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match1[k] = tag_vld[k] & tag_wb[k] & (tag_dest[k] == src1);
            match2[k] = tag_vld[k] & tag_wb[k] & (tag_dest[k] == src2);
        end
    end

`ifdef HAZARD_FWD_EN
    // Only a load still in EXE must stall; everything else forwards, youngest first.
    always_comb begin
        hit1     = match1[0] & tag_memr[0];
        hit2     = match2[0] & tag_memr[0];
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match1[k]) fwd_sel1 = FSEL_W'(k + 1);
            if (match2[k]) fwd_sel2 = FSEL_W'(k + 1);
        end
        if (!issue_valid) begin
            fwd_sel1 = '0;
            fwd_sel2 = '0;
        end
    end
    assign unused_memr = tag_memr[DEPTH-1];
`else
    // Without forwarding any in-flight writer of a source register stalls ID.
    always_comb begin
        hit1     = |match1;
        hit2     = |match2;
        fwd_sel1 = '0;
        fwd_sel2 = '0;
    end
    assign unused_memr = ^tag_memr;
`endif

    assign hazard = issue_valid & (hit1 | (two_src & hit2));
    assign freeze = hazard | mem_stall;
    assign accept = issue_valid & ~hazard & ~flush;

    // Valid bits: cleared by reset, shifted toward retirement unless memory holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld <= '0;
        end else if (!mem_stall) begin
            tag_vld <= {tag_vld[DEPTH-2:0], accept};
        end
    end

    // Tag payload travels with the valid bit; its content is ignored when invalid.
    always_ff @(posedge clk) begin
        if (!mem_stall) begin
            tag_wb   <= {tag_wb[DEPTH-2:0], issue_wb_en};
            tag_memr <= {tag_memr[DEPTH-2:0], issue_mem_r};
            tag_dest[0] <= issue_dest;
            for (int k = 1; k < DEPTH; k++) begin
                tag_dest[k] <= tag_dest[k-1];
            end
        end
    end

    // Performance counter of frozen cycles, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (freeze) begin
            stall_cycles <= sat_inc(stall_cycles);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed vector table plus hand sequences
// for counter saturation and (when built with HAZARD_FWD_EN) forwarding.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic        issue_wb_en;
    logic        issue_mem_r;
    logic [3:0]  issue_dest;
    logic        flush;
    logic        mem_stall;
    logic        freeze;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
    logic [15:0] stall_cycles;
    logic        freeze_s;
    logic [1:0]  fwd_sel1_s;
    logic [1:0]  fwd_sel2_s;
    logic [1:0]  stall_cycles_s;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic       wb;
        logic       mr;
        logic [3:0] dst;
        logic       fl;
        logic       ms;
        logic       ef;
        logic [15:0] ec;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    hazard_scoreboard #(.RADDR_W(4), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .issue_wb_en(issue_wb_en), .issue_mem_r(issue_mem_r),
        .issue_dest(issue_dest), .flush(flush), .mem_stall(mem_stall),
        .freeze(freeze), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall_cycles(stall_cycles)
    );

    // Narrow-counter instance used to reach saturation quickly.
    hazard_scoreboard #(.RADDR_W(4), .DEPTH(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .src1(src1), .src2(src2),
        .two_src(two_src), .issue_wb_en(issue_wb_en), .issue_mem_r(issue_mem_r),
        .issue_dest(issue_dest), .flush(flush), .mem_stall(mem_stall),
        .freeze(freeze_s), .fwd_sel1(fwd_sel1_s), .fwd_sel2(fwd_sel2_s),
        .stall_cycles(stall_cycles_s)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int r, iv, s1, s2, two, wb, mr, dst, fl, ms, ef, ec);
        vec_t v;
        v.rst = 1'(r);   v.iv = 1'(iv);  v.s1 = 4'(s1);  v.s2 = 4'(s2);
        v.two = 1'(two); v.wb = 1'(wb);  v.mr = 1'(mr);  v.dst = 4'(dst);
        v.fl = 1'(fl);   v.ms = 1'(ms);  v.ef = 1'(ef);  v.ec = 16'(ec);
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; issue_valid = v.iv; src1 = v.s1; src2 = v.s2; two_src = v.two;
        issue_wb_en = v.wb; issue_mem_r = v.mr; issue_dest = v.dst;
        flush = v.fl; mem_stall = v.ms;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        next_cycle();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        //            rst iv s1 s2 two wb mr dst fl ms  freeze cnt
        vecs[0]  = mk(0, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0);  // issue R3 writer
        vecs[1]  = mk(0, 1, 3, 0, 0, 1, 0, 8, 0, 0, 1, 0);  // RAW on R3 in EXE
        vecs[2]  = mk(0, 1, 3, 0, 0, 1, 0, 8, 0, 0, 1, 1);  // R3 in MEM
        vecs[3]  = mk(0, 1, 3, 0, 0, 1, 0, 8, 0, 0, 0, 2);  // released, R8 issues
        vecs[4]  = mk(0, 1, 0, 0, 0, 1, 0, 5, 0, 0, 0, 2);  // issue R5 writer
        vecs[5]  = mk(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 2);  // src2=R5 but two_src=0
        vecs[6]  = mk(0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 1, 2);  // two_src=1, R5 in MEM
        vecs[7]  = mk(0, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 3);  // R5 retired
        vecs[8]  = mk(0, 1, 0, 0, 0, 1, 0, 7, 1, 0, 0, 3);  // non-writer dest 0 ignored; R7 flushed
        vecs[9]  = mk(0, 1, 7, 0, 0, 1, 0, 2, 0, 0, 0, 3);  // R7 never entered
        vecs[10] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 3);  // mem_stall with flush
        vecs[11] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4);
        vecs[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 5);
        vecs[13] = mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 6);  // R2 still in EXE
        vecs[14] = mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 7);  // R2 in MEM
        vecs[15] = mk(0, 1, 2, 0, 0, 1, 0, 9, 0, 0, 0, 8);  // issue R9 writer
        vecs[16] = mk(0, 0, 9, 0, 0, 1, 0, 4, 0, 0, 0, 8);  // issue_valid=0 masks hazard
        vecs[17] = mk(0, 1, 9, 0, 0, 1, 0, 4, 1, 0, 1, 8);  // hazard + flush together
        vecs[18] = mk(0, 1, 4, 0, 0, 1, 0, 6, 0, 0, 0, 9);  // R4 was not inserted
        vecs[19] = mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 1, 1, 9);  // reset during mem_stall
        vecs[20] = mk(0, 1, 6, 0, 0, 1, 0, 15, 0, 0, 0, 0); // R6 cleared; issue R15
        vecs[21] = mk(0, 1, 14, 15, 1, 0, 0, 0, 0, 0, 1, 0); // top register via src2
        vecs[22] = mk(0, 1, 7, 7, 1, 0, 0, 0, 0, 0, 0, 1);

        do_reset();
        check("reset_freeze", int'(freeze), 0);
        check("reset_cnt", int'(stall_cycles), 0);

`ifndef HAZARD_FWD_EN
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_freeze", i), int'(freeze), int'(vecs[i].ef));
            check($sformatf("v%0d_cnt", i), int'(stall_cycles), int'(vecs[i].ec));
            check($sformatf("v%0d_fwd", i), int'({fwd_sel1, fwd_sel2}), 0);
            next_cycle();
        end
`endif

        // Counter saturation: 5 memory-wait cycles on a 2-bit counter.
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) next_cycle();
        check("sat_cnt2", int'(stall_cycles_s), 3);
        check("sat_cnt16", int'(stall_cycles), 5);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("sat_release_freeze", int'(freeze_s), 0);
        next_cycle();

        // Load-use: LDR R4 then a reader of R4.
        do_reset();
        drive(mk(0, 1, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0));
        next_cycle();
        drive(mk(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("ldr_exe_freeze", int'(freeze), 1);
        next_cycle();
`ifdef HAZARD_FWD_EN
        check("ldr_mem_freeze", int'(freeze), 0);
        check("ldr_mem_fwd1", int'(fwd_sel1), 2);
        // Two writers of R4 in flight: the younger one in EXE is selected.
        do_reset();
        drive(mk(0, 1, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0));
        next_cycle();
        drive(mk(0, 1, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0));
        next_cycle();
        drive(mk(0, 1, 4, 4, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("youngest_freeze", int'(freeze), 0);
        check("youngest_fwd1", int'(fwd_sel1), 1);
        check("youngest_fwd2", int'(fwd_sel2), 1);
        issue_valid = 1'b0;
        #1;
        check("idle_fwd1", int'(fwd_sel1), 0);
`else
        check("ldr_mem_freeze", int'(freeze), 1);
        next_cycle();
        check("ldr_done_freeze", int'(freeze), 0);
        check("ldr_cnt", int'(stall_cycles), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
